// File: rtl/deser_lane_arbiter_pkg.sv
// Shared types and helpers for the deserializer lane arbiter.
package deser_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int TIMEOUT_CYC_DEF = 64;

  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/deser_lane_arbiter_rr_pick.sv
// Rotating-priority picker: first requester strictly after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] index
);

  int c;

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    onehot = '0;
    index  = '0;
    c      = 0;
    for (int i = N; i >= 1; i--) begin
      c = (int'(ptr) + i) % N;
      if (req[c]) begin
        onehot    = '0;
        onehot[c] = 1'b1;
        index     = W'(c);
      end
    end
  end

endmodule

// File: rtl/deser_lane_arbiter.sv
// Round-robin arbiter sharing one deserializer among N_CH serial lanes, with a 1-entry output register.
// Optional stall timeout with deserializer flush: define DESER_ARB_TIMEOUT_EN.
module deser_lane_arbiter
  import deser_arb_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int LENGTH = 24,
`ifdef DESER_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
`endif
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [N_CH-1:0]   iv_req,
  input  logic [N_CH-1:0]   iv_din,
  input  logic [N_CH-1:0]   iv_din_valid,
  output logic [N_CH-1:0]   ov_grant,
  output logic              o_deser_en,
  output logic              o_deser_din,
  output logic              o_deser_din_valid,
  input  logic              i_deser_ready,
  input  logic [LENGTH-1:0] iv_deser_dout,
  input  logic              i_deser_dout_valid,
  output logic              o_deser_ready,
  output logic              o_deser_flush,
  output logic [LENGTH-1:0] ov_dout,
  output logic [CH_W-1:0]   ov_dout_ch,
  output logic              o_dout_valid,
  input  logic              i_ready
);

  // state | meaning
  // IDLE  | waiting for a requester and a ready deserializer
  // SHIFT | granted lane streams LENGTH valid bits into the deserializer
  // DRAIN | waiting to move the parallel word into the output register

  localparam int CNT_W = $clog2(LENGTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LENGTH - 1);

  state_t            state;
  logic [N_CH-1:0]   pick_oh;
  logic [CH_W-1:0]   pick_idx;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   lane;
  logic [CNT_W-1:0]  bit_cnt;
  logic              start;
  logic              bit_valid;
  logic              last_bit;
  logic              load;
  logic              timeout;

  rr_pick #(.N(N_CH), .W(CH_W)) u_pick (
    .req    (iv_req),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .index  (pick_idx)
  );

  assign start     = (state == IDLE) && i_en && (|iv_req) && i_deser_ready;
  assign bit_valid = (state == SHIFT) && i_en && iv_din_valid[lane];
  assign last_bit  = bit_valid && (bit_cnt == LAST_BIT);
  assign load      = (state == DRAIN) && i_en && i_deser_dout_valid && (!o_dout_valid || i_ready);

  assign o_deser_en        = i_en;
  assign o_deser_din       = (state == SHIFT) && iv_din[lane];
  assign o_deser_din_valid = bit_valid;
  assign o_deser_ready     = load;

`ifdef DESER_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               flush;

  assign timeout = (state == SHIFT) && i_en && !iv_din_valid[lane] &&
                   (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));
  assign o_deser_flush = flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt <= '0;
      flush     <= 1'b0;
    end else begin
      flush <= timeout;
      if (state != SHIFT || bit_valid || timeout) stall_cnt <= '0;
      else if (i_en) stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  assign timeout       = 1'b0;
  assign o_deser_flush = 1'b0;
`endif

  // rr_ptr already holds the granted lane, so a timeout naturally moves priority past it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      rr_ptr   <= CH_W'(N_CH - 1);
      lane     <= '0;
      ov_grant <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ov_grant <= pick_oh;
            lane     <= pick_idx;
            rr_ptr   <= pick_idx;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (timeout || last_bit) begin
            bit_cnt  <= '0;
            ov_grant <= '0;
            state    <= timeout ? IDLE : DRAIN;
          end else if (bit_valid) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (load) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ov_dout      <= '0;
      ov_dout_ch   <= '0;
      o_dout_valid <= 1'b0;
    end else if (load) begin
      ov_dout      <= iv_deser_dout;
      ov_dout_ch   <= lane;
      o_dout_valid <= 1'b1;
    end else if (i_ready) begin
      o_dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deser_lane_arbiter.sv
// Bench for deser_lane_arbiter: random lane sources, a deserializer stand-in and an in-order word scoreboard.
module tb_deser_lane_arbiter;

  localparam int N_CH   = 4;
  localparam int LENGTH = 24;
  localparam int CH_W   = 2;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_en = 1'b0;
  logic [N_CH-1:0]   iv_req = '0;
  logic [N_CH-1:0]   iv_din = '0;
  logic [N_CH-1:0]   iv_din_valid = '0;
  logic [N_CH-1:0]   ov_grant;
  logic              o_deser_en, o_deser_din, o_deser_din_valid;
  logic              i_deser_ready;
  logic [LENGTH-1:0] iv_deser_dout;
  logic              i_deser_dout_valid;
  logic              o_deser_ready, o_deser_flush;
  logic [LENGTH-1:0] ov_dout;
  logic [CH_W-1:0]   ov_dout_ch;
  logic              o_dout_valid;
  logic              i_ready = 1'b0;

  always #5 i_clk = ~i_clk;

  deser_lane_arbiter #(.N_CH(N_CH), .LENGTH(LENGTH)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_en               (i_en),
    .iv_req             (iv_req),
    .iv_din             (iv_din),
    .iv_din_valid       (iv_din_valid),
    .ov_grant           (ov_grant),
    .o_deser_en         (o_deser_en),
    .o_deser_din        (o_deser_din),
    .o_deser_din_valid  (o_deser_din_valid),
    .i_deser_ready      (i_deser_ready),
    .iv_deser_dout      (iv_deser_dout),
    .i_deser_dout_valid (i_deser_dout_valid),
    .o_deser_ready      (o_deser_ready),
    .o_deser_flush      (o_deser_flush),
    .ov_dout            (ov_dout),
    .ov_dout_ch         (ov_dout_ch),
    .o_dout_valid       (o_dout_valid),
    .i_ready            (i_ready)
  );

  // Deserializer stand-in: LSB-first shift, word valid until consumed, cleared by reset or flush.
  logic [LENGTH-1:0] ds_sh;
  int                ds_cnt;
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ds_sh              <= '0;
      ds_cnt             <= 0;
      iv_deser_dout      <= '0;
      i_deser_dout_valid <= 1'b0;
    end else if (o_deser_flush) begin
      ds_cnt             <= 0;
      i_deser_dout_valid <= 1'b0;
    end else begin
      if (o_deser_ready) i_deser_dout_valid <= 1'b0;
      if (o_deser_din_valid && o_deser_en) begin
        ds_sh <= {o_deser_din, ds_sh[LENGTH-1:1]};
        if (ds_cnt == LENGTH - 1) begin
          iv_deser_dout      <= {o_deser_din, ds_sh[LENGTH-1:1]};
          i_deser_dout_valid <= 1'b1;
          ds_cnt             <= 0;
        end else begin
          ds_cnt <= ds_cnt + 1;
        end
      end
    end
  end
  assign i_deser_ready = !i_deser_dout_valid;

  // Lane sources and scoreboard state
  logic [LENGTH-1:0] word [N_CH];
  int                idx  [N_CH];
  int                left [N_CH];
  int                stop [N_CH];
  logic [N_CH-1:0]   solid = '0;
  logic [N_CH-1:0]   take  = '0;
  logic [LENGTH-1:0] exp_w [$];
  int                exp_c [$];
  int passed = 0, failed = 0, total = 0;
  int delivered = 0, pulses = 0, flushes = 0, flush_at = -1, stall_run = 0, rr_exp = 0;
  bit rr_mode = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit busy();
    for (int n = 0; n < N_CH; n++) if (left[n] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: sample what the coming edge consumes, then advance the lane sources and redrive.
  task automatic tick();
    logic acc;
    #1;
    take = ov_grant & iv_din_valid & {N_CH{i_en}};
    acc  = o_dout_valid & i_ready;
    if (o_deser_ready) pulses++;
    if (acc) begin
      if (exp_w.size() == 0) begin
        check("spurious_word", o_dout_valid, 1'b0);
      end else begin
        check("word", ov_dout, exp_w[0]);
        check("word_ch", ov_dout_ch, exp_c[0]);
        if (rr_mode) begin
          check("rr_order", ov_dout_ch, rr_exp);
          rr_exp = (rr_exp + 1) % N_CH;
        end
        void'(exp_w.pop_front());
        void'(exp_c.pop_front());
        delivered++;
      end
    end
    if (take != 0) stall_run = 0;
    else if (ov_grant != 0) stall_run++;
    @(negedge i_clk);
    for (int n = 0; n < N_CH; n++) begin
      if (take[n]) begin
        idx[n]++;
        if (idx[n] == LENGTH) begin
          exp_w.push_back(word[n]);
          exp_c.push_back(n);
          idx[n] = 0;
          left[n]--;
          word[n] = LENGTH'($urandom);
        end
      end
      iv_req[n] = left[n] > 0;
      iv_din[n] = word[n][idx[n]];
      if (left[n] > 0) iv_din_valid[n] = (idx[n] < stop[n]) && (solid[n] || $urandom_range(3) != 0);
      else             iv_din_valid[n] = 1'($urandom_range(1));
    end
    #1;
    if (o_deser_flush) begin
      flushes++;
      flush_at = stall_run;
    end
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int k = 0;
    while ((busy() || exp_w.size() != 0 || o_dout_valid) && k < budget) begin
      tick();
      k++;
    end
    check(tag, k < budget, 1'b1);
  endtask

  task automatic wait_grant(input string tag, input int budget);
    int k = 0;
    while (ov_grant == 0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, ov_grant != 0, 1'b1);
  endtask

  initial begin
    int p0, d0, f0, k;
    logic [LENGTH-1:0] w1;
    for (int n = 0; n < N_CH; n++) begin
      word[n] = LENGTH'($urandom);
      idx[n]  = 0;
      left[n] = 0;
      stop[n] = LENGTH;
    end

    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    #1;
    check("rst_grant", ov_grant, '0);
    check("rst_dout_valid", o_dout_valid, 1'b0);
    check("rst_dout", ov_dout, '0);
    check("rst_din_valid", o_deser_din_valid, 1'b0);
    i_rst   = 1'b0;
    i_en    = 1'b1;
    i_ready = 1'b1;

    // All lanes request two words each: strict 0,1,2,3 rotation.
    for (int n = 0; n < N_CH; n++) left[n] = 2;
    rr_mode = 1'b1;
    rr_exp  = 0;
    run_until_done("t2_done", 3000);
    check("t2_count", delivered, 8);
    rr_mode = 1'b0;

    // Lane 2 alone.
    word[2] = 24'hFF00FF;
    left[2] = 1;
    p0 = pulses;
    wait_grant("t1_grant_seen", 100);
    check("t1_grant", ov_grant, 4'b0100);
    run_until_done("t1_done", 500);
    check("t1_pulses", pulses - p0, 1);
    check("t1_dout", ov_dout, 24'hFF00FF);
    check("t1_ch", ov_dout_ch, 2);

    // Downstream back-pressure: word 1 parked, word 2 stalls in DRAIN.
    i_ready = 1'b0;
    d0 = delivered;
    p0 = pulses;
    w1 = word[0];
    left[0] = 1;
    k = 0;
    while (!(left[0] == 0 && o_dout_valid) && k < 300) begin tick(); k++; end
    check("t3_word1_parked", o_dout_valid, 1'b1);
    left[1] = 1;
    k = 0;
    while (left[1] != 0 && k < 300) begin tick(); k++; end
    repeat (10) tick();
    check("t3_stall_pulses", pulses - p0, 1);
    check("t3_hold_dout", ov_dout, w1);
    check("t3_no_delivery", delivered - d0, 0);
    i_ready = 1'b1;
    run_until_done("t3_done", 300);
    check("t3_delivered", delivered - d0, 2);
    check("t3_pulses", pulses - p0, 2);

    // Enable dropped for 10 cycles at bit 12.
    word[0]  = 24'hAF5EB9;
    solid[0] = 1'b1;
    left[0]  = 1;
    k = 0;
    while (idx[0] != 12 && k < 200) begin tick(); k++; end
    check("t4_reach_bit12", idx[0], 12);
    i_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t4_din_valid_low", o_deser_din_valid, 1'b0);
    end
    check("t4_grant_held", ov_grant, 4'b0001);
    i_en = 1'b1;
    run_until_done("t4_done", 300);
    check("t4_dout", ov_dout, 24'hAF5EB9);
    solid[0] = 1'b0;

    // Asynchronous reset at bit 7 of lane 3; lane 0 also requesting afterwards.
    solid[3] = 1'b1;
    left[3]  = 1;
    k = 0;
    while (idx[3] != 7 && k < 200) begin tick(); k++; end
    left[0] = 1;
    i_rst = 1'b1;
    #1;
    check("t5_grant", ov_grant, '0);
    check("t5_dout_valid", o_dout_valid, 1'b0);
    check("t5_dout", ov_dout, '0);
    check("t5_din_valid", o_deser_din_valid, 1'b0);
    check("t5_deser_ready", o_deser_ready, 1'b0);
    for (int n = 0; n < N_CH; n++) idx[n] = 0;
    tick();
    tick();
    i_rst = 1'b0;
    wait_grant("t5_grant_seen", 100);
    check("t5_first_grant", ov_grant, 4'b0001);
    run_until_done("t5_done", 500);
    solid[3] = 1'b0;

`ifdef DESER_ARB_TIMEOUT_EN
    // Lane 1 stalls after 5 bits and is timed out.
    f0 = flushes;
    d0 = delivered;
    solid[1] = 1'b1;
    stop[1]  = 5;
    left[1]  = 1;
    k = 0;
    while (flushes == f0 && k < 300) begin tick(); k++; end
    check("t6_flush_seen", flushes - f0, 1);
    check("t6_flush_cycle", flush_at, 64);
    check("t6_no_word", o_dout_valid, 1'b0);
    left[1]  = 0;
    idx[1]   = 0;
    stop[1]  = LENGTH;
    solid[1] = 1'b0;
    left[2]  = 1;
    tick();
    check("t6_flush_width", o_deser_flush, 1'b0);
    wait_grant("t6_grant_seen", 100);
    check("t6_next_grant", ov_grant, 4'b0100);
    run_until_done("t6_done", 500);
    check("t6_delivered", delivered - d0, 1);
`else
    // Without the timeout a stalled lane keeps its grant.
    f0 = flushes;
    solid[1] = 1'b1;
    stop[1]  = 5;
    left[1]  = 1;
    repeat (100) tick();
    check("t6_grant_held", ov_grant, 4'b0010);
    check("t6_no_flush", flushes - f0, 0);
    stop[1] = LENGTH;
    run_until_done("t6_done", 500);
    solid[1] = 1'b0;
`endif

    check("final_queue_empty", exp_w.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
